aether_engine_task_scheduler: RTL and testbench

- Queues START_TASK commands from the instruction decoder and issues them one at a time to the tasked RAM and the convolution engine.
- Waits for each task to complete, then raises completion interrupts and error flags.
- Its FIFO is the decoder's command buffer, so its full flag drives the decoder's buffer-full output.
- Sits between the decoder and the RAM/conv datapaths.

---
 rtl/aether_engine_pkg.sv | 39 +++
 rtl/aether_cmd_fifo.sv | 75 +++++++
 rtl/aether_engine_task_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_aether_engine_task_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aether_engine_pkg.sv
// Shared opcodes, task codes, FSM states and error-bit indices
// for the Aether engine task scheduler.
package aether_engine_pkg;

  localparam logic [3:0] OP_NOP        = 4'h0;
  localparam logic [3:0] OP_RESET      = 4'h1;
  localparam logic [3:0] OP_WRITE_REG  = 4'h2;
  localparam logic [3:0] OP_READ_REG   = 4'h3;
  localparam logic [3:0] OP_START_TASK = 4'h4;

  typedef enum logic [3:0] {
    T_LOAD_CONV_WEIGHTS = 4'd0,
    T_LOAD_CONV_DATA    = 4'd1,
    T_START_CONV        = 4'd2,
    T_DENSE_0           = 4'd3,
    T_DENSE_1           = 4'd4,
    T_DENSE_2           = 4'd5,
    T_WRITE_TO_MEM      = 4'd6,
    T_READ_FROM_MEM     = 4'd7
  } task_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RAM,
    S_WAIT_CONV
  } state_e;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  code;
    logic [15:0] addr_lsb;
  } cmd_t;

  localparam int ERR_OVF = 0;
  localparam int ERR_ILL = 1;
  localparam int ERR_TMO = 2;

endpackage

// File: rtl/aether_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty/count
// and a single-cycle flush.
module aether_cmd_fifo #(
  parameter int Width = 24,
  parameter int Depth = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [Width-1:0]       data_i,
  output logic [Width-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i & ~full_q & ~flush_i;
  assign pop_ok  = pop_i & ~empty_q & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push_ok)
                        - (AW+1)'(pop_ok);
    end
    full_d  = (count_d == (AW+1)'(Depth));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign count_o = count_q;

endmodule

// File: rtl/aether_engine_task_scheduler.sv
// Queues START_TASK commands and issues them one at a time to
// the task RAM or conv engine, with timeout and sticky errors.
module aether_engine_task_scheduler
  import aether_engine_pkg::*;
#(
  parameter int CmdDepth      = 8,
  parameter int TimeoutCycles = 65535
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [23:0]               cmd_i,
  input  logic                      cmd_valid_i,
  output logic                      buffer_full_o,
  input  logic                      flush_i,
  input  logic [15:0]               ram_addr_high_i,
  output logic                      ram_read_en_o,
  output logic                      ram_write_en_o,
  output logic [3:0]                ram_task_o,
  output logic [31:0]               ram_addr_o,
  input  logic                      ram_done_i,
  output logic                      conv_start_o,
  input  logic                      conv_done_i,
  output logic                      irq_mem_o,
  output logic                      irq_conv_o,
  output logic                      busy_o,
  output logic [$clog2(CmdDepth):0] queue_count_o,
  output logic [2:0]                err_o
);

  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TimeoutCycles - 1);

  state_e      state_q, state_d;
  logic [3:0]  code_q, code_d;
  logic [31:0] addr_q, addr_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0]  err_q, err_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic        conv_q, conv_d;
  logic        irq_mem_q, irq_mem_d;
  logic        irq_conv_q, irq_conv_d;

  logic        cmd_ok, push, pop, empty;
  logic [23:0] head_raw;
  cmd_t        head;
  logic        unused_opcode;

  assign cmd_ok = (cmd_i[23:20] == OP_START_TASK);
  assign push   = cmd_valid_i & cmd_ok & ~buffer_full_o;
  assign pop    = (state_q == S_IDLE) & ~empty;
  assign head   = cmd_t'(head_raw);
  assign unused_opcode = ^head.opcode;

  aether_cmd_fifo #(
    .Width (24),
    .Depth (CmdDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (cmd_i),
    .data_o  (head_raw),
    .full_o  (buffer_full_o),
    .empty_o (empty),
    .count_o (queue_count_o)
  );

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    addr_d     = addr_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    rd_en_d    = 1'b0;
    wr_en_d    = 1'b0;
    conv_d     = 1'b0;
    irq_mem_d  = 1'b0;
    irq_conv_d = 1'b0;
    if (!flush_i && cmd_valid_i) begin
      if (!cmd_ok)            err_d[ERR_ILL] = 1'b1;
      else if (buffer_full_o) err_d[ERR_OVF] = 1'b1;
    end
    if (flush_i) begin
      state_d = S_IDLE;
      code_d  = '0;
      addr_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (!empty) begin
          state_d = S_ISSUE;
          code_d  = head.code;
          addr_d  = {ram_addr_high_i, head.addr_lsb};
          case (head.code)
            T_LOAD_CONV_WEIGHTS,
            T_LOAD_CONV_DATA,
            T_READ_FROM_MEM: rd_en_d = 1'b1;
            T_WRITE_TO_MEM:  wr_en_d = 1'b1;
            T_START_CONV:    conv_d  = 1'b1;
            default: ;
          endcase
        end
        S_ISSUE: begin
          tmo_d = '0;
          case (code_q)
            T_LOAD_CONV_WEIGHTS,
            T_LOAD_CONV_DATA,
            T_READ_FROM_MEM,
            T_WRITE_TO_MEM: state_d = S_WAIT_RAM;
            T_START_CONV:   state_d = S_WAIT_CONV;
            default: begin
              err_d[ERR_ILL] = 1'b1;
              state_d = S_IDLE;
              code_d  = '0;
              addr_d  = '0;
            end
          endcase
        end
        S_WAIT_RAM, S_WAIT_CONV: begin
          // done wins over a same-cycle timeout expiry
          if (state_q == S_WAIT_RAM ? ram_done_i
                                    : conv_done_i) begin
            irq_mem_d  = (state_q == S_WAIT_RAM);
            irq_conv_d = (state_q == S_WAIT_CONV);
            state_d = S_IDLE;
            code_d  = '0;
            addr_d  = '0;
          end else if (tmo_q == TMO_LAST) begin
            err_d[ERR_TMO] = 1'b1;
            state_d = S_IDLE;
            code_d  = '0;
            addr_d  = '0;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      code_q     <= '0;
      addr_q     <= '0;
      tmo_q      <= '0;
      err_q      <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      conv_q     <= 1'b0;
      irq_mem_q  <= 1'b0;
      irq_conv_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      addr_q     <= addr_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      conv_q     <= conv_d;
      irq_mem_q  <= irq_mem_d;
      irq_conv_q <= irq_conv_d;
    end
  end

  assign ram_read_en_o  = rd_en_q;
  assign ram_write_en_o = wr_en_q;
  assign conv_start_o   = conv_q;
  assign ram_task_o     = code_q;
  assign ram_addr_o     = addr_q;
  assign irq_mem_o      = irq_mem_q;
  assign irq_conv_o     = irq_conv_q;
  assign err_o          = err_q;
  assign busy_o = (state_q != S_IDLE) | (queue_count_o != '0);

endmodule

// File: tb/tb_aether_engine_task_scheduler.sv
// Directed bench for the task scheduler with a short timeout
// so expiry and overflow are reachable in a few dozen cycles.
module tb_aether_engine_task_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [23:0] cmd_i = '0;
  logic        cmd_valid_i = 1'b0;
  logic        buffer_full_o;
  logic        flush_i = 1'b0;
  logic [15:0] ram_addr_high_i = '0;
  logic        ram_read_en_o;
  logic        ram_write_en_o;
  logic [3:0]  ram_task_o;
  logic [31:0] ram_addr_o;
  logic        ram_done_i = 1'b0;
  logic        conv_start_o;
  logic        conv_done_i = 1'b0;
  logic        irq_mem_o;
  logic        irq_conv_o;
  logic        busy_o;
  logic [3:0]  queue_count_o;
  logic [2:0]  err_o;

  int n_checks = 0;
  int n_errors = 0;

  aether_engine_task_scheduler #(
    .CmdDepth      (8),
    .TimeoutCycles (16)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .cmd_i           (cmd_i),
    .cmd_valid_i     (cmd_valid_i),
    .buffer_full_o   (buffer_full_o),
    .flush_i         (flush_i),
    .ram_addr_high_i (ram_addr_high_i),
    .ram_read_en_o   (ram_read_en_o),
    .ram_write_en_o  (ram_write_en_o),
    .ram_task_o      (ram_task_o),
    .ram_addr_o      (ram_addr_o),
    .ram_done_i      (ram_done_i),
    .conv_start_o    (conv_start_o),
    .conv_done_i     (conv_done_i),
    .irq_mem_o       (irq_mem_o),
    .irq_conv_o      (irq_conv_o),
    .busy_o          (busy_o),
    .queue_count_o   (queue_count_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_count", 32'(queue_count_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_full", 32'(buffer_full_o), 0);
    chk("rst_addr", ram_addr_o, 0);
    chk("rst_rd", 32'(ram_read_en_o), 0);
    rst_i = 1'b0;

    // single LOAD_CONV_WEIGHTS
    ram_addr_high_i = 16'h0002;
    cmd_i = 24'h400010;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    chk("s1_count", 32'(queue_count_o), 1);
    chk("s1_busy", 32'(busy_o), 1);
    chk("s1_rd_early", 32'(ram_read_en_o), 0);
    tick();
    chk("s1_rd", 32'(ram_read_en_o), 1);
    chk("s1_addr", ram_addr_o, 32'h0002_0010);
    chk("s1_task", 32'(ram_task_o), 0);
    chk("s1_count0", 32'(queue_count_o), 0);
    tick();
    chk("s1_rd_pulse", 32'(ram_read_en_o), 0);
    chk("s1_addr_hold", ram_addr_o, 32'h0002_0010);
    repeat (4) tick();
    ram_done_i = 1'b1;
    tick();
    ram_done_i = 1'b0;
    chk("s1_irq", 32'(irq_mem_o), 1);
    chk("s1_busy_fall", 32'(busy_o), 0);
    chk("s1_addr_idle", ram_addr_o, 0);
    tick();
    chk("s1_irq_pulse", 32'(irq_mem_o), 0);

    // START_CONV then READ_FROM_MEM
    cmd_i = 24'h420000;
    cmd_valid_i = 1'b1;
    tick();
    cmd_i = 24'h470100;
    tick();
    cmd_valid_i = 1'b0;
    chk("s2_conv", 32'(conv_start_o), 1);
    chk("s2_task", 32'(ram_task_o), 2);
    chk("s2_rd0", 32'(ram_read_en_o), 0);
    chk("s2_count", 32'(queue_count_o), 1);
    tick();
    chk("s2_conv_pulse", 32'(conv_start_o), 0);
    repeat (3) tick();
    chk("s2_rd_wait", 32'(ram_read_en_o), 0);
    chk("s2_busy", 32'(busy_o), 1);
    ram_done_i = 1'b1;
    tick();
    ram_done_i = 1'b0;
    chk("s2_wrong_done", 32'(irq_mem_o), 0);
    conv_done_i = 1'b1;
    tick();
    conv_done_i = 1'b0;
    chk("s2_irq_conv", 32'(irq_conv_o), 1);
    chk("s2_rd_idle", 32'(ram_read_en_o), 0);
    tick();
    chk("s2_rd", 32'(ram_read_en_o), 1);
    chk("s2_task7", 32'(ram_task_o), 7);
    chk("s2_addr", ram_addr_o, 32'h0002_0100);
    chk("s2_irq_pulse", 32'(irq_conv_o), 0);
    tick();
    ram_done_i = 1'b1;
    tick();
    ram_done_i = 1'b0;
    chk("s2_irq_mem", 32'(irq_mem_o), 1);
    tick();

    // overflow: 10 pushes, one issued, 8 queued, last dropped
    cmd_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cmd_i = 24'h470000 | 24'(i);
      tick();
    end
    cmd_valid_i = 1'b0;
    chk("ovf_count", 32'(queue_count_o), 8);
    chk("ovf_full", 32'(buffer_full_o), 1);
    chk("ovf_err", 32'(err_o), 3'b001);
    repeat (8) tick();
    chk("tmo_not_yet", 32'(err_o), 3'b001);
    tick();
    chk("tmo_err", 32'(err_o), 3'b101);
    chk("tmo_task", 32'(ram_task_o), 0);
    chk("tmo_irq", 32'(irq_mem_o), 0);
    tick();
    chk("tmo_next_rd", 32'(ram_read_en_o), 1);
    chk("tmo_next_task", 32'(ram_task_o), 7);
    chk("tmo_next_addr", ram_addr_o, 32'h0002_0001);
    chk("tmo_next_cnt", 32'(queue_count_o), 7);
    chk("tmo_next_full", 32'(buffer_full_o), 0);
    tick();

    // flush mid WAIT_RAM beats a same-cycle done
    flush_i = 1'b1;
    ram_done_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_count", 32'(queue_count_o), 0);
    chk("fl_irq", 32'(irq_mem_o), 0);
    chk("fl_busy", 32'(busy_o), 0);
    chk("fl_err", 32'(err_o), 3'b101);
    chk("fl_task", 32'(ram_task_o), 0);
    tick();
    ram_done_i = 1'b0;
    chk("fl_late_done", 32'(irq_mem_o), 0);
    chk("fl_idle", 32'(busy_o), 0);

    // illegal opcode
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst2_err", 32'(err_o), 0);
    cmd_i = 24'h200000;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    chk("ill_op_count", 32'(queue_count_o), 0);
    chk("ill_op_err", 32'(err_o), 3'b010);
    chk("ill_op_busy", 32'(busy_o), 0);

    // unimplemented dense task
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    cmd_i = 24'h440000;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    chk("ill_tk_rd", 32'(ram_read_en_o), 0);
    chk("ill_tk_wr", 32'(ram_write_en_o), 0);
    chk("ill_tk_conv", 32'(conv_start_o), 0);
    chk("ill_tk_task", 32'(ram_task_o), 4);
    tick();
    chk("ill_tk_err", 32'(err_o), 3'b010);
    chk("ill_tk_busy", 32'(busy_o), 0);
    chk("ill_tk_irq", 32'(irq_mem_o), 0);

    // write task, then reset mid-wait
    ram_addr_high_i = 16'hBEEF;
    cmd_i = 24'h46ABCD;
    cmd_valid_i = 1'b1;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    chk("wr_en", 32'(ram_write_en_o), 1);
    chk("wr_rd0", 32'(ram_read_en_o), 0);
    chk("wr_addr", ram_addr_o, 32'hBEEF_ABCD);
    chk("wr_task", 32'(ram_task_o), 6);
    tick();
    rst_i = 1'b1;
    ram_done_i = 1'b1;
    tick();
    rst_i = 1'b0;
    ram_done_i = 1'b0;
    chk("mrst_irq", 32'(irq_mem_o), 0);
    chk("mrst_err", 32'(err_o), 0);
    chk("mrst_busy", 32'(busy_o), 0);
    chk("mrst_addr", ram_addr_o, 0);
    tick();
    chk("mrst_irq2", 32'(irq_mem_o), 0);

    $display("Result: errors=%0d of %0d checks",
             n_errors, n_checks);
    $finish;
  end

endmodule
